// File: rtl/reg_stack.sv
// reg_stack: parametrised LIFO register stack with push, pop, replace-top and
// synchronous clear, all gated by a global enable. The top word is a
// zero-latency combinational read of the registered storage.
// Optional feature macro: REG_STACK_ERR_EN adds a sticky overflow/underflow
// flag on port err.
module reg_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
`ifdef REG_STACK_ERR_EN
  ,
  output logic                       err
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    top_pos;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    wr_idx;
  logic             wr_en;
  logic             is_empty;
  logic             is_full;
`ifdef REG_STACK_ERR_EN
  logic             err_q, err_d;
`endif

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign top_pos  = count_q - 1'b1;
  assign rd_idx   = IW'(top_pos);

  // Next-state decode: reset and disable suppress writes; clr beats push/pop;
  // push+pop on a non-empty stack overwrites the top in place.
  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
`ifdef REG_STACK_ERR_EN
    err_d   = err_q;
`endif
    if (rst && en) begin
      if (clr) begin
        count_d = '0;
`ifdef REG_STACK_ERR_EN
        err_d   = 1'b0;
`endif
      end else if (push && pop) begin
        wr_en = 1'b1;
        if (is_empty) begin
          wr_idx  = '0;
          count_d = CW'(1);
        end else begin
          wr_idx = rd_idx;
        end
      end else if (push) begin
        if (!is_full) begin
          wr_en   = 1'b1;
          wr_idx  = IW'(count_q);
          count_d = count_q + 1'b1;
        end else begin
`ifdef REG_STACK_ERR_EN
          err_d = 1'b1;
`endif
        end
      end else if (pop) begin
        if (!is_empty) begin
          count_d = count_q - 1'b1;
        end else begin
`ifdef REG_STACK_ERR_EN
          err_d = 1'b1;
`endif
        end
      end
    end
  end

  // Storage next-state: only the addressed entry takes din on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_idx] = din;
    end
  end

  // Control registers: synchronous active-low reset empties the stack.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
`ifdef REG_STACK_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
`ifdef REG_STACK_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Entry storage is never reset; stale words stay hidden behind count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign top   = is_empty ? '0 : mem_q[rd_idx];
  assign count = count_q;
  assign empty = is_empty;
  assign full  = is_full;
`ifdef REG_STACK_ERR_EN
  assign err   = err_q;
`endif

endmodule

// File: tb/tb_reg_stack.sv
// Self-checking bench for reg_stack (WIDTH=8, DEPTH=4) against a queue-based
// reference model. Define REG_STACK_ERR_EN to also exercise the err flag.
module tb_reg_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] top;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
`ifdef REG_STACK_ERR_EN
  logic             err;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: the stack as a queue, last element is the top.
  logic [WIDTH-1:0] q [$];
  logic             m_err = 1'b0;

  reg_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .top   (top),
    .count (count),
    .empty (empty),
    .full  (full)
`ifdef REG_STACK_ERR_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] m_top();
    if (q.size() == 0) return '0;
    return q[q.size()-1];
  endfunction

  // Apply one cycle of controls to the DUT and to the model.
  task automatic drive(input logic r, input logic e, input logic c,
                       input logic pu, input logic po, input logic [WIDTH-1:0] d);
    rst = r; en = e; clr = c; push = pu; pop = po; din = d;
    @(posedge clk);
    #1;
    if (!r) begin
      q.delete(); m_err = 1'b0;
    end else if (e) begin
      if (c) begin
        q.delete(); m_err = 1'b0;
      end else if (pu && po) begin
        if (q.size() == 0) q.push_back(d);
        else q[q.size()-1] = d;
      end else if (pu) begin
        if (q.size() < DEPTH) q.push_back(d);
        else m_err = 1'b1;
      end else if (po) begin
        if (q.size() > 0) void'(q.pop_back());
        else m_err = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h99);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (count !== 3'd0 || top !== 8'h00 || empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset: count=%0d top=%h empty=%b full=%b, required 0 00 1 0",
               count, top, empty, full);
    end
`ifdef REG_STACK_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err: err=%b required 0", err);
    end
`endif
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 8'h11 * (i + 1);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, v);
      checks++;
      if (count !== CW'(i + 1) || top !== v) begin
        failures++;
        $display("FAIL fill%0d: count=%0d top=%h, required %0d %h", i, count, top, i + 1, v);
      end
    end
    checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: full=%b empty=%b, required 1 0", full, empty);
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
    checks++;
    if (count !== 3'd4 || top !== 8'h44 || full !== 1'b1) begin
      failures++;
      $display("FAIL overflow: count=%0d top=%h full=%b, required 4 44 1", count, top, full);
    end
`ifdef REG_STACK_ERR_EN
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL overflow_err: err=%b required 1", err);
    end
`endif
  endtask

  task automatic test_drain();
    logic [WIDTH-1:0] exp_top [5] = '{8'h33, 8'h22, 8'h11, 8'h00, 8'h00};
    int               exp_cnt [5] = '{3, 2, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hEE);
      checks++;
      if (count !== CW'(exp_cnt[i]) || top !== exp_top[i]) begin
        failures++;
        $display("FAIL drain%0d: count=%0d top=%h, required %0d %h",
                 i, count, top, exp_cnt[i], exp_top[i]);
      end
`ifdef REG_STACK_ERR_EN
      checks++;
      if (err !== 1'b1) begin
        failures++;
        $display("FAIL drain_err%0d: err=%b required 1 (sticky)", i, err);
      end
`endif
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: empty=%b full=%b, required 1 0", empty, full);
    end
  endtask

  task automatic test_replace();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAA);
    checks++;
    if (count !== 3'd2 || top !== 8'hAA) begin
      failures++;
      $display("FAIL replace: count=%0d top=%h, required 2 aa", count, top);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    checks++;
    if (count !== 3'd1 || top !== 8'h11) begin
      failures++;
      $display("FAIL replace_pop: count=%0d top=%h, required 1 11", count, top);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
    checks++;
    if (count !== 3'd1 || top !== 8'h5A || empty !== 1'b0) begin
      failures++;
      $display("FAIL replace_empty: count=%0d top=%h empty=%b, required 1 5a 0",
               count, top, empty);
    end
    // Replace on a full stack is legal and must not flag an error.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC3);
    checks++;
    if (count !== 3'd4 || top !== 8'hC3 || full !== 1'b1) begin
      failures++;
      $display("FAIL replace_full: count=%0d top=%h full=%b, required 4 c3 1", count, top, full);
    end
`ifdef REG_STACK_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL replace_err: err=%b required 0", err);
    end
`endif
  endtask

  task automatic test_priority();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h7E);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81);
    checks++;
    if (count !== 3'd1 || top !== 8'h7E) begin
      failures++;
      $display("FAIL en_hold: count=%0d top=%h, required 1 7e", count, top);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    checks++;
    if (count !== 3'd1 || top !== 8'h7E) begin
      failures++;
      $display("FAIL en_hold_clr: count=%0d top=%h, required 1 7e", count, top);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
`ifdef REG_STACK_ERR_EN
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL underflow_err: err=%b required 1", err);
    end
`endif
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h12);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h34);
    checks++;
    if (count !== 3'd0 || top !== 8'h00 || empty !== 1'b1) begin
      failures++;
      $display("FAIL clr_push: count=%0d top=%h empty=%b, required 0 00 1", count, top, empty);
    end
`ifdef REG_STACK_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL clr_err: err=%b required 0", err);
    end
`endif
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA2);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA3);
    checks++;
    if (count !== 3'd0 || top !== 8'h00 || empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: count=%0d top=%h empty=%b full=%b, required 0 00 1 0",
               count, top, empty, full);
    end
  endtask

  task automatic test_random();
    logic r, e, c, pu, po;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) != 0);
      e  = ($urandom_range(0, 9) != 0);
      c  = ($urandom_range(0, 24) == 0);
      pu = $urandom_range(0, 1) == 1;
      po = $urandom_range(0, 2) == 0;
      drive(r, e, c, pu, po, 8'($urandom));
      checks++;
      if (count !== CW'(q.size()) || top !== m_top() ||
          empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
        failures++;
        $display("FAIL random%0d: count=%0d top=%h empty=%b full=%b, required %0d %h %b %b",
                 i, count, top, empty, full, q.size(), m_top(),
                 q.size() == 0, q.size() == DEPTH);
      end
`ifdef REG_STACK_ERR_EN
      checks++;
      if (err !== m_err) begin
        failures++;
        $display("FAIL random_err%0d: err=%b required %b", i, err, m_err);
      end
`endif
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_replace();
    test_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_stack.md
# reg_stack

Parametrised LIFO register stack: the multi-entry successor to the single enabled, zero-clearable register. It holds up to DEPTH words of WIDTH bits and supports push, pop, replace-top and synchronous clear, all gated by a global enable. It sits in the datapath wherever operand or return values must be stacked, such as expression evaluation or call/return storage, and exposes the current top word together with occupancy flags.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 8, number of entries (≥2; need not be a power of two)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  global enable; when 0, all state holds regardless of other controls
- clr  in  1  synchronous clear of the stack (empties it); acted on only when en=1
- push  in  1  push din onto the stack
- pop  in  1  discard the top entry
- din  in  WIDTH  data to push or to replace the top with
- top  out  WIDTH  current top entry; 0 when empty
- count  out  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- err  out  1  sticky overflow/underflow flag; present only with REG_STACK_ERR_EN

## Operation
- Control priority on each rising edge: rst==0 > en==0 (hold) > clr > push/pop.
- rst==0: count←0; err←0. Entry storage is not cleared; top is forced to 0 while empty.
- clr (en=1): count←0; err←0. push and pop are ignored in the same cycle.
- push only:
  - Not full: mem[count]←din; count←count+1.
  - Full: no state change (overflow).
- pop only:
  - Not empty: count←count-1. The popped entry's data is left in place.
  - Empty: no state change (underflow).
- push and pop together:
  - Not empty: replace top. mem[count-1]←din; count is unchanged. This is legal when full.
  - Empty: treated as push only; count 0→1 and top=din.
- top = mem[count-1] when count>0, else 0. It is a combinational read of registered state.
- empty and full are decoded combinationally from count.
- Arithmetic: count never wraps; it stays within 0..DEPTH under all input sequences.

## Timing
- Outputs after reset: top=0, count=0, empty=1, full=0, err=0.
- Every output reflects the state after the most recent rising edge, so there is zero-cycle read latency. A push at edge N shows on top immediately after edge N.
- No handshake. The caller must observe full and empty; ignored operations are silent unless REG_STACK_ERR_EN is defined.
- Back-to-back operations are allowed on every cycle.
- Reset asserted mid-sequence takes effect at the next edge and overrides en, clr, push and pop.
- din is sampled only on the edge where a write occurs.

## Configuration
- REG_STACK_ERR_EN defined:
  - The err port exists.
  - err←1 on any enabled push-only while full, or pop-only while empty.
  - err stays at 1 until reset or clr.
  - Replace-top operations never set err.
- REG_STACK_ERR_EN not defined:
  - The err port and its logic are absent.
  - Overflow and underflow are silently ignored.
  - All other behaviour is identical.

## Test plan
- Reset and fill, WIDTH=8, DEPTH=4: release rst, then push 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Expect count 1,2,3,4 and top 0x11,0x22,0x33,0x44.
  - Expect full=1 after the 4th push.
- Overflow: with the stack full, push 0x55.
  - Expect count=4 and top=0x44 unchanged.
  - With REG_STACK_ERR_EN, expect err=1, sticky, surviving later valid pops.
- Drain and underflow: pop 5 times from full.
  - Expect top 0x33, 0x22, 0x11, 0, then 0; count 3,2,1,0,0; empty=1.
  - Expect err=1 on the 5th pop (macro builds only).
- Replace and simultaneous ops:
  - With stack [0x11,0x22], assert push+pop with din=0xAA: expect count=2, top=0xAA.
  - From empty, assert push+pop with din=0x5A: expect count=1, top=0x5A.
- Enable/clear/reset priority:
  - en=0 with push=1: no change.
  - clr=1 with push=1 and en=1: count=0, err=0.
  - rst=0 with en=1, push=1 mid-fill: all outputs return to reset values at the next edge.
